// File: rtl/reg_file_clr.sv
// Two-read, one-write register file with a self-timed zero-fill sweep.
// Reset and clear requests both run the sweep; reads return zero while it runs.
module reg_file_clr #(
    parameter int N        = 32,
    parameter int DEPTH    = 16,
    parameter int ZERO_REG = 0,
    parameter int BYPASS   = 1,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] address1_i,
    input  logic [AW-1:0] address2_i,
    input  logic [AW-1:0] address3_i,
    input  logic [N-1:0]  write_data_i,
    input  logic          write_enable_i,
    input  logic          clear_req_i,
    output logic [N-1:0]  output1_o,
    output logic [N-1:0]  output2_o,
    output logic          busy_o,
    output logic          clear_done_o
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] CLEAR = 1'b1;

    logic [0:0]    state;
    logic [AW-1:0] cnt;
    logic [N-1:0]  regs [DEPTH];
    logic          last;
    logic          wr_ok;

    assign busy_o       = (state == CLEAR);
    assign last         = (cnt == AW'(DEPTH - 1));
    assign clear_done_o = busy_o && last;
    assign wr_ok        = write_enable_i &&
                          !(ZERO_REG != 0 && address3_i == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= CLEAR;
            cnt   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (clear_req_i) begin
                        state <= CLEAR;
                        cnt   <= '0;
                    end
                end
                CLEAR: begin
                    cnt <= cnt + AW'(1);
                    if (last) state <= IDLE;
                end
                default: begin
                    state <= CLEAR;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // The array itself is never reset; only the sweep zeroes it.
    always_ff @(posedge clk) begin
        if (busy_o) begin
            regs[cnt] <= '0;
        end else if (wr_ok) begin
            regs[address3_i] <= write_data_i;
        end
    end

    function automatic logic [N-1:0] rd(input logic [AW-1:0] a);
        logic [N-1:0] v;
        v = regs[a];
        if (BYPASS != 0 && write_enable_i && a == address3_i) begin
            v = write_data_i;
        end
        if (ZERO_REG != 0 && a == '0) v = '0;
        if (busy_o) v = '0;
        return v;
    endfunction

    always_comb begin
        output1_o = rd(address1_i);
        output2_o = rd(address2_i);
    end

endmodule
